// File: rtl/hex_pio_arbiter.sv
// Round-robin arbiter that shares one Avalon hex-digit PIO among NUM_REQ
// requesters. A grant latches the winner's 16-bit value, issues one PIO
// write, acks the winner, and then holds off for DWELL_CYCLES cycles.
module hex_pio_arbiter #(
  parameter int NUM_REQ      = 3,
  parameter int DWELL_CYCLES = 50000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [16*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]      ack,
  output logic                    pio_chipselect,
  output logic                    pio_write_n,
  output logic [1:0]              pio_address,
  output logic [31:0]             pio_writedata,
  output logic [1:0]              owner,
  output logic                    busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_ACK   = 2'd2;
  localparam logic [1:0] S_DWELL = 2'd3;

  logic [1:0]  state;
  logic [1:0]  grant_idx;   // doubles as "last grant index" for round-robin
  logic [15:0] data_q;
  logic [19:0] cnt;
  logic [1:0]  owner_q;

  logic [3:0]  req_ext;
  logic [1:0]  cand;
  logic        pick_vld;
  logic [1:0]  pick_idx;
  logic [15:0] pick_data;

  // Round-robin pick: scan upward from the slot after the last grant, wrapping.
  always_comb begin
    req_ext   = 4'(req);
    cand      = '0;
    pick_vld  = 1'b0;
    pick_idx  = grant_idx;
    pick_data = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = 2'((int'(grant_idx) + k) % NUM_REQ);
      if (!pick_vld && req_ext[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
    for (int i = 0; i < NUM_REQ; i++)
      if (int'(pick_idx) == i) pick_data = req_data[16*i +: 16];
  end

  // FSM, data latch, grant index, owner and dwell counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      grant_idx <= 2'(NUM_REQ - 1);
      data_q    <= '0;
      cnt       <= '0;
      owner_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_vld) begin
            state     <= S_WRITE;
            grant_idx <= pick_idx;
            data_q    <= pick_data;
          end
        end
        S_WRITE: begin
          state   <= S_ACK;
          owner_q <= grant_idx;   // owner is valid in the same cycle as ack
        end
        S_ACK: begin
          if (DWELL_CYCLES > 0) begin
            state <= S_DWELL;
            cnt   <= 20'(DWELL_CYCLES - 1);
          end else begin
            state <= S_IDLE;
          end
        end
        default: begin
          if (cnt == '0) state <= S_IDLE;
          else           cnt   <= cnt - 20'd1;
        end
      endcase
    end
  end

  // Outputs decode straight from state so reset drops the bus immediately.
  always_comb begin
    pio_chipselect = (state == S_WRITE);
    pio_write_n    = (state != S_WRITE);
    pio_address    = 2'b00;
    pio_writedata  = (state == S_WRITE) ? {16'h0000, data_q} : 32'h0;
    owner          = owner_q;
    busy           = (state != S_IDLE);
    ack            = '0;
    for (int i = 0; i < NUM_REQ; i++)
      ack[i] = (state == S_ACK) && (int'(grant_idx) == i);
  end

endmodule

// File: tb/tb_hex_pio_arbiter.sv
// Directed bench: a 3-requester arbiter with a 4-cycle dwell, and a
// 2-requester arbiter with no dwell, sharing clock and reset.
module tb_hex_pio_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  req;
  logic [47:0] req_data;
  logic [2:0]  ack;
  logic        cs, wn, busy;
  logic [1:0]  addr, owner;
  logic [31:0] wd;

  logic [1:0]  r0;
  logic [31:0] d0;
  logic [1:0]  a0;
  logic        cs0, wn0, busy0;
  logic [1:0]  addr0, owner0;
  logic [31:0] wd0;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  hex_pio_arbiter #(.NUM_REQ(3), .DWELL_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_data(req_data), .ack(ack),
    .pio_chipselect(cs), .pio_write_n(wn), .pio_address(addr),
    .pio_writedata(wd), .owner(owner), .busy(busy));

  hex_pio_arbiter #(.NUM_REQ(2), .DWELL_CYCLES(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .req(r0), .req_data(d0), .ack(a0),
    .pio_chipselect(cs0), .pio_write_n(wn0), .pio_address(addr0),
    .pio_writedata(wd0), .owner(owner0), .busy(busy0));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50; i++) begin
      if (!busy) break;
      step();
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    int          wcyc[$];
    logic [15:0] wdat[$];
    int          maxpop;
    logic        seen_cs, seen_ack;
    logic [15:0] exp_rr[5];
    logic [15:0] exp_ab[4];

    // reset state
    reset_n = 1'b0; req = '0; req_data = '0; r0 = '0; d0 = '0;
    #12;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_cs", 32'(cs), 32'd0);
    chk("rst_wn", 32'(wn), 32'd1);
    chk("rst_wd", wd, 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_busy0", 32'(busy0), 32'd0);
    reset_n = 1'b1;
    step();

    // single requester 1, 4-cycle dwell
    req = 3'b010; req_data[31:16] = 16'hBEEF;
    chk("t1_idle", 32'(busy), 32'd0);
    step();
    chk("t1_cs", 32'(cs), 32'd1);
    chk("t1_wn", 32'(wn), 32'd0);
    chk("t1_wd", wd, 32'h0000BEEF);
    chk("t1_addr", 32'(addr), 32'd0);
    chk("t1_noack", 32'(ack), 32'd0);
    step();
    chk("t1_ack", 32'(ack), 32'b010);
    chk("t1_owner", 32'(owner), 32'd1);
    chk("t1_cs_off", 32'(cs), 32'd0);
    chk("t1_wd_off", wd, 32'd0);
    req = '0;
    step(); step(); step(); step();
    chk("t1_dwell_busy", 32'(busy), 32'd1);
    chk("t1_dwell_ack", 32'(ack), 32'd0);
    step();
    chk("t1_busy_low", 32'(busy), 32'd0);
    chk("t1_owner_hold", 32'(owner), 32'd1);

    // all three held: round-robin order 0,1,2,0,1 with 7-cycle spacing
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    req = 3'b111; req_data = {16'h3333, 16'h2222, 16'h1111};
    exp_rr = '{16'h1111, 16'h2222, 16'h3333, 16'h1111, 16'h2222};
    maxpop = 0;
    for (int c = 1; c <= 30; c++) begin
      step();
      if (cs) begin wcyc.push_back(c); wdat.push_back(wd[15:0]); end
      if ($countones(ack) > maxpop) maxpop = $countones(ack);
    end
    chk("rr_nwrites", 32'(wcyc.size()), 32'd5);
    for (int i = 0; i < 5 && i < wcyc.size(); i++) begin
      chk($sformatf("rr_data%0d", i), 32'(wdat[i]), 32'(exp_rr[i]));
      if (i > 0) chk($sformatf("rr_gap%0d", i), 32'(wcyc[i] - wcyc[i-1]), 32'd7);
    end
    if (wcyc.size() > 0) chk("rr_first", 32'(wcyc[0]), 32'd1);
    chk("rr_onehot", 32'(maxpop <= 1), 32'd1);
    req = '0;
    wait_idle();

    // req[2] raised in dwell and withdrawn before idle
    req = 3'b001; req_data[15:0] = 16'h0042;
    step();
    step();
    chk("t3_ack0", 32'(ack), 32'b001);
    req = '0;
    step();
    req = 3'b100;
    step(); step();
    req = '0;
    seen_cs = 1'b0; seen_ack = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (cs) seen_cs = 1'b1;
      if (ack != '0) seen_ack = 1'b1;
    end
    chk("t3_no_write", 32'(seen_cs), 32'd0);
    chk("t3_no_ack", 32'(seen_ack), 32'd0);
    chk("t3_idle", 32'(busy), 32'd0);

    // data latched at grant
    req = 3'b001; req_data[15:0] = 16'h0001;
    step();
    req_data[15:0] = 16'hFFFF;
    #1;
    chk("t4_cs", 32'(cs), 32'd1);
    chk("t4_wd", wd, 32'h00000001);
    step();
    chk("t4_ack", 32'(ack), 32'b001);
    chk("t4_owner", 32'(owner), 32'd0);
    req = '0;
    wait_idle();

    // reset mid-write aborts; next grant restarts at requester 0
    req = 3'b111; req_data = {16'h3333, 16'h2222, 16'h1111};
    step();
    chk("t5_cs", 32'(cs), 32'd1);
    chk("t5_wd", wd, 32'h00002222);
    reset_n = 1'b0;
    #1;
    chk("t5_rst_cs", 32'(cs), 32'd0);
    chk("t5_rst_wn", 32'(wn), 32'd1);
    chk("t5_rst_wd", wd, 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    step();
    chk("t5_rst_ack", 32'(ack), 32'd0);
    chk("t5_rst_owner", 32'(owner), 32'd0);
    reset_n = 1'b1;
    step();
    chk("t5_regrant_wd", wd, 32'h00001111);
    step();
    chk("t5_regrant_ack", 32'(ack), 32'b001);
    req = '0;
    wait_idle();

    // zero dwell, two requesters: grants every 3 cycles, alternating
    wcyc.delete(); wdat.delete(); maxpop = 0;
    exp_ab = '{16'hAAAA, 16'h5555, 16'hAAAA, 16'h5555};
    r0 = 2'b11; d0 = {16'h5555, 16'hAAAA};
    for (int c = 1; c <= 12; c++) begin
      step();
      if (cs0) begin wcyc.push_back(c); wdat.push_back(wd0[15:0]); end
      if ($countones(a0) > maxpop) maxpop = $countones(a0);
    end
    chk("z_nwrites", 32'(wcyc.size()), 32'd4);
    for (int i = 0; i < 4 && i < wcyc.size(); i++) begin
      chk($sformatf("z_data%0d", i), 32'(wdat[i]), 32'(exp_ab[i]));
      if (i > 0) chk($sformatf("z_gap%0d", i), 32'(wcyc[i] - wcyc[i-1]), 32'd3);
    end
    chk("z_onehot", 32'(maxpop <= 1), 32'd1);
    r0 = '0;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
